arb_egress_queue: RTL and testbench
===================================

Name: arb_egress_queue

Overview:
- Sits directly downstream of arbitrated_fifos and consumes its one-hot grant vector and granted data word.
- Encodes the granted source index and buffers (source, data) pairs in a small circular queue.
- Presents the pairs on a valid/ready stream and returns an accept signal that the integration gates into the arbiter's reqs.
- Flags protocol violations with sticky error bits that formal wrappers can assert against.

Parameters:
- NUM_REQS, 2, number of arbitrated sources; width of gnt.
- WIDTH, 8, data word width; matches FIFO_DWIDTH of the upstream FIFOs.
- DEPTH, 4, queue entries; power of two, at least 2.
- SRCW, $clog2(NUM_REQS) (minimum 1), width of encoded source index.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- gnt  input  NUM_REQS  arbiter grant (the pop vector); one-hot or zero.
- data_in  input  WIDTH  arbiter data_out; valid in the same cycle as a non-zero gnt.
- out_ready  input  1  downstream consumer ready.
- out_valid  output  1  head entry valid.
- out_data  output  WIDTH  head entry data.
- out_src  output  SRCW  head entry source index.
- can_accept  output  1  queue will take a grant this cycle; integration ANDs it into reqs.
- overflow  output  1  sticky: a grant arrived while can_accept was 0.
- gnt_err  output  1  sticky: gnt had more than one bit set.

Behaviour:
- Reset (rst=1 at posedge):
  - rd_ptr=0, wr_ptr=0, count=0.
  - out_valid=0, overflow=0, gnt_err=0.
  - can_accept=1 in the first cycle after reset.
  - Queue contents are not reset. out_data and out_src are don't-care while out_valid=0.
  - Reset asserted mid-stream discards all entries. Any gnt in the reset cycle is ignored and does not set sticky bits.
- Signal definitions:
  - push = |gnt.
  - pop = out_valid & out_ready.
  - can_accept = (count < DEPTH). It is a function of registered state only; there is no combinational path from gnt, data_in or out_ready.
  - out_valid = (count != 0). out_data and out_src come from the entry at rd_ptr (first-word fall-through from storage).
- Enqueue (push & can_accept):
  - Write {enc(gnt), data_in} at wr_ptr.
  - wr_ptr wraps modulo DEPTH.
  - enc gives the index of the lowest set bit of gnt.
- Latency: a pair enqueued at cycle N is visible at the output in cycle N+1 at the earliest. There is no empty-queue bypass.
- Dequeue on pop: rd_ptr advances modulo DEPTH.
- count update:
  - +1 on enqueue only.
  - −1 on pop only.
  - Unchanged on simultaneous enqueue and pop, including at count=DEPTH-1 and count=1.
- Full (count=DEPTH):
  - can_accept=0.
  - A push in this cycle is dropped, even if a pop occurs in the same cycle, and sets overflow.
  - The pop proceeds normally.
- Empty (count=0): out_ready is ignored and pointers hold.
- gnt_err:
  - Set when $countones(gnt)>1 outside reset.
  - The entry is still enqueued using the lowest-index source.
- Sticky bits clear only on rst.
- Pointers are $clog2(DEPTH) bits wide. count is $clog2(DEPTH)+1 bits wide. No arithmetic overflow is possible within these widths.
- Formal: under `ifdef FORMAL`, assert count<=DEPTH, out_valid==(count!=0), and !overflow whenever the integration honours can_accept.

Decomposition:
- Shared package arb_pkg:
  - Default localparams for NUM_REQS, WIDTH, DEPTH.
  - Function onehot_to_idx (lowest set bit).
  - Function is_multi_hot.
- One sub-module, egress_ring: a storage array with wr_ptr, rd_ptr and count, exposing push, pop, full, empty and head.
- The top of the block adds source encoding, accept generation and sticky error logic.

Test Plan:
- Reset, then gnt=2'b01 with data_in=8'hA5 for one cycle, out_ready=1 → next cycle out_valid=1, out_data=A5, out_src=0; the following cycle out_valid=0.
- out_ready=0; grants 01/A0, 10/B1, 01/C2, 10/D3 on consecutive cycles → can_accept=0 after the fourth; raise out_ready → output order A0/0, B1/1, C2/0, D3/1, then out_valid=0.
- Queue full, gnt=2'b10 with data_in=EE and out_ready=1 in the same cycle → EE is dropped, overflow=1 and stays 1; count=3 next cycle.
- count=1, simultaneous grant 01/55 and pop → count stays 1, head becomes 55; run 10 cycles of streaming to cover pointer wrap past DEPTH-1 → data order preserved.
- gnt=2'b11 with data_in=77 → gnt_err=1 sticky; entry 77 is enqueued with out_src=0.
- Four entries queued, rst=1 for one cycle with gnt=01 applied → next cycle out_valid=0, can_accept=1, overflow=0, gnt_err=0, and no entry is enqueued.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared defaults and grant-vector helpers for the arbiter egress queue.
package arb_pkg;
    localparam int DEF_NUM_REQS = 2;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DEPTH    = 4;
    localparam int VEC_W        = 32;

    function automatic logic [4:0] onehot_to_idx(input logic [VEC_W-1:0] vec);
        logic [4:0] idx;
        logic       found;
        idx   = 5'd0;
        found = 1'b0;
        for (int i = 0; i < VEC_W; i++) begin
            if (vec[i] && !found) begin
                idx   = 5'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic logic is_multi_hot(input logic [VEC_W-1:0] vec);
        return ((vec & (vec - 32'd1)) != 32'd0);
    endfunction
endpackage

// File: rtl/egress_ring.sv
// Circular buffer with first-word fall-through head; pushes are dropped when full.
module egress_ring
    import arb_pkg::*;
#(
    parameter int EW    = 9,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [EW-1:0] wr_data_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [EW-1:0] head_o,
    output logic [CW-1:0] count_o
);
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == CW'(0));
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next-state for pointers and occupancy; power-of-two depth wraps naturally.
    always_comb begin
        do_push_s = push_i & ~full_o;
        do_pop_s  = pop_i & ~empty_o;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; only occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push_s && !rst) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end
endmodule

// File: rtl/arb_egress_queue.sv
// Egress queue behind the arbiter: encodes the grant, buffers (source, data)
// pairs and reports protocol violations through sticky flags.
module arb_egress_queue
    import arb_pkg::*;
#(
    parameter int NUM_REQS = DEF_NUM_REQS,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int SRCW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQS-1:0] gnt,
    input  logic [WIDTH-1:0]    data_in,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [WIDTH-1:0]    out_data,
    output logic [SRCW-1:0]     out_src,
    output logic                can_accept,
    output logic                overflow,
    output logic                gnt_err
);
    localparam int EW = SRCW + WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            empty_s;
    logic [SRCW-1:0] src_s;
    logic [EW-1:0]   head_s;
    logic [CW-1:0]   count_s;
    logic            overflow_q, overflow_d;
    logic            gnt_err_q, gnt_err_d;

    assign push_s     = |gnt;
    assign src_s      = SRCW'(onehot_to_idx(VEC_W'(gnt)));
    assign out_valid  = ~empty_s;
    assign pop_s      = out_valid & out_ready;
    assign can_accept = ~full_s;
    assign out_src    = head_s[WIDTH +: SRCW];
    assign out_data   = head_s[WIDTH-1:0];
    assign overflow   = overflow_q;
    assign gnt_err    = gnt_err_q;

    egress_ring #(
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push_s),
        .pop_i     (pop_s),
        .wr_data_i ({src_s, data_in}),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .head_o    (head_s),
        .count_o   (count_s)
    );

    // Sticky error accumulation.
    always_comb begin
        overflow_d = overflow_q | (push_s & full_s);
        gnt_err_d  = gnt_err_q | is_multi_hot(VEC_W'(gnt));
    end

    // Sticky error registers; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
            gnt_err_q  <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            gnt_err_q  <= gnt_err_d;
        end
    end

`ifdef FORMAL
    // Integration contract and structural invariants.
    always_comb begin
        if (!can_accept) begin
            assume (gnt == '0);
        end else begin
            assume (1'b1);
        end
        assert (count_s <= CW'(DEPTH));
        assert (out_valid == (count_s != CW'(0)));
        assert (!overflow);
    end
`endif
endmodule

// File: tb/tb_arb_egress_queue.sv
// Directed bench: stimulus pushes expected pairs into a scoreboard queue, a
// separate monitor pops and compares on every output handshake.
module tb_arb_egress_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gnt;
    logic [7:0] data_in;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [0:0] out_src;
    logic       can_accept;
    logic       overflow;
    logic       gnt_err;

    int checks = 0;
    int fails  = 0;
    logic [8:0] exp_q[$];

    arb_egress_queue dut (
        .clk        (clk),
        .rst        (rst),
        .gnt        (gnt),
        .data_in    (data_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .can_accept (can_accept),
        .overflow   (overflow),
        .gnt_err    (gnt_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; expected pair is queued by the caller.
    task automatic step(input logic [1:0] g, input logic [7:0] d, input logic r);
        gnt       = g;
        data_in   = d;
        out_ready = r;
        @(posedge clk);
        #1;
        gnt     = 2'b00;
        data_in = 8'h00;
    endtask

    task automatic push_step(input logic [1:0] g, input logic src, input logic [7:0] d, input logic r);
        exp_q.push_back({src, d});
        step(g, d, r);
    endtask

    // Monitor: compare the head against the scoreboard whenever a pop will occur.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {23'd0, out_src, out_data}, 32'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
                    chk("out_src", {31'd0, out_src}, {31'd0, e[8]});
                end
            end
        end
    end

    initial begin
        rst = 1'b1; gnt = 2'b00; data_in = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_can_accept", {31'd0, can_accept}, 32'd1);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_gnt_err", {31'd0, gnt_err}, 32'd0);

        // Single transfer: visible one cycle later, gone the cycle after.
        push_step(2'b01, 1'b0, 8'hA5, 1'b1);
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        step(2'b00, 8'h00, 1'b1);
        chk("single_empty", {31'd0, out_valid}, 32'd0);

        // Fill to DEPTH with the consumer stalled.
        push_step(2'b01, 1'b0, 8'hA0, 1'b0);
        push_step(2'b10, 1'b1, 8'hB1, 1'b0);
        push_step(2'b01, 1'b0, 8'hC2, 1'b0);
        push_step(2'b10, 1'b1, 8'hD3, 1'b0);
        chk("full_can_accept", {31'd0, can_accept}, 32'd0);
        chk("full_overflow_clear", {31'd0, overflow}, 32'd0);

        // Grant while full is dropped even though a pop happens this cycle.
        step(2'b10, 8'hEE, 1'b1);
        chk("drop_overflow", {31'd0, overflow}, 32'd1);
        chk("drop_count3_accept", {31'd0, can_accept}, 32'd1);
        repeat (3) step(2'b00, 8'h00, 1'b1);
        chk("drain_empty", {31'd0, out_valid}, 32'd0);
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);

        // Simultaneous enqueue and pop at count=1.
        push_step(2'b01, 1'b0, 8'h11, 1'b0);
        push_step(2'b01, 1'b0, 8'h55, 1'b1);
        chk("swap_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        step(2'b00, 8'h00, 1'b0);
        chk("swap_count1_accept", {31'd0, can_accept}, 32'd1);
        step(2'b00, 8'h00, 1'b1);
        chk("swap_drained", {31'd0, out_valid}, 32'd0);

        // Streaming past the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) push_step(2'b01, 1'b0, 8'h60 + 8'(i), 1'b1);
            else            push_step(2'b10, 1'b1, 8'h60 + 8'(i), 1'b1);
        end
        step(2'b00, 8'h00, 1'b1);
        chk("stream_empty", {31'd0, out_valid}, 32'd0);

        // Multi-hot grant: flagged, enqueued as the lowest source.
        push_step(2'b11, 1'b0, 8'h77, 1'b0);
        chk("gnt_err_set", {31'd0, gnt_err}, 32'd1);
        step(2'b00, 8'h00, 1'b1);
        chk("gnt_err_sticky", {31'd0, gnt_err}, 32'd1);
        chk("overflow_still_set", {31'd0, overflow}, 32'd1);

        // Mid-stream reset with a grant applied discards everything.
        push_step(2'b01, 1'b0, 8'h81, 1'b0);
        push_step(2'b10, 1'b1, 8'h82, 1'b0);
        push_step(2'b01, 1'b0, 8'h83, 1'b0);
        push_step(2'b10, 1'b1, 8'h84, 1'b0);
        exp_q.delete();
        rst = 1'b1;
        step(2'b01, 8'h99, 1'b0);
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_accept", {31'd0, can_accept}, 32'd1);
        chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
        chk("mid_rst_gnt_err", {31'd0, gnt_err}, 32'd0);
        step(2'b00, 8'h00, 1'b1);
        chk("mid_rst_no_enqueue", {31'd0, out_valid}, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
